mem_writer: RTL



---
 rtl/mem_writer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_writer.sv
// mem_writer: write-side bus master.
// Accepts one write command from the execute stage (STORE, PUSH8, PUSH16),
// drives the memory write cycles on the shared bus, then reports the new
// stack pointer together with a single-cycle done pulse. All outputs are
// registered; address/data are held at zero whenever no write is strobed.

module mem_writer #(
  parameter int unsigned REG_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-REG_WIDTH-1:0] STACK_PAGE = 8'h01
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req,
  input  logic [1:0]             cmd,
  input  logic [ADDR_WIDTH-1:0]  addr_in,
  input  logic [2*REG_WIDTH-1:0] data_in,
  input  logic [REG_WIDTH-1:0]   sp_in,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [REG_WIDTH-1:0]   mem_data_out,
  output logic                   mem_we,
  output logic [REG_WIDTH-1:0]   sp_out,
  output logic                   sp_we
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR0  = 2'd1,
    WR1  = 2'd2,
    FIN  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CMD_STORE  = 2'b00,
    CMD_PUSH8  = 2'b01,
    CMD_PUSH16 = 2'b10,
    CMD_RSVD   = 2'b11
  } cmd_t;

  state_t                 state;
  cmd_t                   cmd_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [2*REG_WIDTH-1:0] data_q;
  logic [REG_WIDTH-1:0]   sp_q;

  // Latched operand views and stack-pointer arithmetic. The subtraction is
  // kept at REG_WIDTH so it wraps inside the stack page.
  logic [REG_WIDTH-1:0]  data_lo;
  logic [REG_WIDTH-1:0]  data_hi;
  logic [REG_WIDTH-1:0]  sp_dec1;
  logic [REG_WIDTH-1:0]  sp_dec2;
  logic [ADDR_WIDTH-1:0] stack_addr0;
  logic [ADDR_WIDTH-1:0] stack_addr1;

  assign data_lo     = data_q[REG_WIDTH-1:0];
  assign data_hi     = data_q[2*REG_WIDTH-1:REG_WIDTH];
  assign sp_dec1     = sp_q - REG_WIDTH'(1);
  assign sp_dec2     = sp_q - REG_WIDTH'(2);
  assign stack_addr0 = {STACK_PAGE, sp_q};
  assign stack_addr1 = {STACK_PAGE, sp_dec1};

  // Command sequencer: accepts a request in IDLE, issues one write per byte,
  // then signals completion and the stack pointer update in FIN.
  // NOTE: every register in this block is assigned with <= so all of them
  // see the pre-edge values of each other; a blocking = here would let a
  // later statement observe a value updated earlier in the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the latched operands are cleared as well as the control state,
      // so a reset mid-command leaves nothing that could leak into a later
      // command; this is a handful of flops, not a memory array.
      state        <= IDLE;
      cmd_q        <= CMD_STORE;
      addr_q       <= '0;
      data_q       <= '0;
      sp_q         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      mem_addr     <= '0;
      mem_data_out <= '0;
      mem_we       <= 1'b0;
      sp_out       <= '0;
      sp_we        <= 1'b0;
    end else begin
      // Strobes and the bus default to idle each cycle; a state re-asserts
      // only what it drives, so address/data are zero whenever mem_we is low.
      done         <= 1'b0;
      err          <= 1'b0;
      mem_addr     <= '0;
      mem_data_out <= '0;
      mem_we       <= 1'b0;
      sp_out       <= '0;
      sp_we        <= 1'b0;

      case (state)
        IDLE: begin
          busy <= req;
          if (req) begin
            cmd_q  <= cmd_t'(cmd);
            addr_q <= addr_in;
            data_q <= data_in;
            sp_q   <= sp_in;
            // A reserved command skips the write phase entirely.
            state  <= (cmd_t'(cmd) == CMD_RSVD) ? FIN : WR0;
          end
        end

        WR0: begin
          mem_we <= 1'b1;
          case (cmd_q)
            CMD_STORE: begin
              mem_addr     <= addr_q;
              mem_data_out <= data_lo;
              state        <= FIN;
            end
            CMD_PUSH8: begin
              mem_addr     <= stack_addr0;
              mem_data_out <= data_lo;
              state        <= FIN;
            end
            CMD_PUSH16: begin
              // High byte goes to the current top of stack first.
              mem_addr     <= stack_addr0;
              mem_data_out <= data_hi;
              state        <= WR1;
            end
            default: begin
              // Unreachable: reserved commands never enter WR0.
              mem_we <= 1'b0;
              state  <= FIN;
            end
          endcase
        end

        WR1: begin
          // Second byte of PUSH16 one slot below, wrapping within the page.
          mem_we       <= 1'b1;
          mem_addr     <= stack_addr1;
          mem_data_out <= data_lo;
          state        <= FIN;
        end

        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b1;
          err   <= (cmd_q == CMD_RSVD);
          state <= IDLE;
          case (cmd_q)
            CMD_PUSH8: begin
              sp_we  <= 1'b1;
              sp_out <= sp_dec1;
            end
            CMD_PUSH16: begin
              sp_we  <= 1'b1;
              sp_out <= sp_dec2;
            end
            default: begin
              sp_we  <= 1'b0;
              sp_out <= '0;
            end
          endcase
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
